// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit add/sub/and/xor ALU between two requesters.
// Optional Y86 condition codes (port 0 results only) are built when ALU_ARB_CC_EN is defined.
module alu_arbiter #(
   parameter int WIDTH      = 32,
   parameter bit START_PRIO = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_id,
   output logic [WIDTH-1:0] res_val,
   output logic             res_of,
   output logic             cc_zf,
   output logic             cc_sf,
   output logic             cc_of
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                  state_q, state_d;
   logic                    prio_q, prio_d;
   logic [1:0]              op_q, op_d;
   logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic                    id_q, id_d;
   logic [WIDTH-1:0]        val_q, val_d;
   logic                    of_q, of_d;
   logic                    rid_q, rid_d;
   logic                    grant0, grant1;

   // Returns {overflow, result}; overflow is signed overflow for add/sub only.
   function automatic logic [WIDTH:0] alu_eval(input logic [1:0] op,
                                               input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] r;
      logic                    ov;
      r  = '0;
      ov = 1'b0;
      unique case (op)
         2'b00: begin
            r  = a + b;
            ov = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         2'b01: begin
            r  = a - b;
            ov = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         2'b10: r = a & b;
         2'b11: r = a ^ b;
      endcase
      return {ov, r};
   endfunction

   assign grant0 = req0_valid && (!req1_valid || !prio_q);
   assign grant1 = req1_valid && !grant0;

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      id_d       = id_q;
      val_d      = val_q;
      of_d       = of_q;
      rid_d      = rid_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      unique case (state_q)
         IDLE: begin
            req0_ready = grant0 && rst_n;
            req1_ready = grant1 && rst_n;
            if (grant0) begin
               op_d    = req0_op;
               a_d     = req0_a;
               b_d     = req0_b;
               id_d    = 1'b0;
               state_d = EXEC;
            end else if (grant1) begin
               op_d    = req1_op;
               a_d     = req1_a;
               b_d     = req1_b;
               id_d    = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            {of_d, val_d} = alu_eval(op_q, a_q, b_q);
            rid_d         = id_q;
            state_d       = RESP;
         end
         RESP: begin
            if (res_ready) begin
               prio_d  = ~rid_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prio_q  <= START_PRIO;
         op_q    <= 2'b00;
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= 1'b0;
         val_q   <= '0;
         of_q    <= 1'b0;
         rid_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
         val_q   <= val_d;
         of_q    <= of_d;
         rid_q   <= rid_d;
      end
   end

   assign res_valid = (state_q == RESP);
   assign res_id    = rid_q;
   assign res_val   = val_q;
   assign res_of    = of_q;

`ifdef ALU_ARB_CC_EN
   logic zf_q, sf_q, ccof_q;
   logic cc_upd;

   assign cc_upd = res_valid && res_ready && !rid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zf_q   <= 1'b1;
         sf_q   <= 1'b0;
         ccof_q <= 1'b0;
      end else if (cc_upd) begin
         zf_q   <= (val_q == '0);
         sf_q   <= val_q[WIDTH-1];
         ccof_q <= of_q;
      end
   end

   assign cc_zf = zf_q;
   assign cc_sf = sf_q;
   assign cc_of = ccof_q;
`else
   assign cc_zf = 1'b0;
   assign cc_sf = 1'b0;
   assign cc_of = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit `alu` datapath (add/sub/and/xor with overflow) between two requesters: port 0 is the execute stage and port 1 is the address/auxiliary computation path. A round-robin grant picks one request at a time. The block registers the operands and registers the result. It then returns the result with a requester tag over a valid/ready handshake. It also maintains the Y86 condition-code register (ZF/SF/OF), which only port 0 results update.

## Interface
- `WIDTH`, 32, operand/result width; fixed at 32 to match `alu`.
- `START_PRIO`, 0, requester that holds priority after reset (0 or 1).

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  port 0 request pending.
- `req0_ready`  out  1  port 0 request accepted this cycle.
- `req0_op`  in  2  00 add, 01 sub (a−b), 10 and, 11 xor.
- `req0_a`, `req0_b`  in  32  port 0 signed operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: port 1 equivalents.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_id`  out  1  requester the result belongs to.
- `res_val`  out  32  ALU result.
- `res_of`  out  1  ALU overflow (0 for and/xor).
- `cc_zf`, `cc_sf`, `cc_of`  out  1 each  condition-code register.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE:**
  - The winner is the valid requester. If both requesters are valid, the winner is the one holding priority.
  - `reqN_ready` is asserted combinationally for the winner only, and only in IDLE.
  - On `valid && ready`, the block latches op/a/b and the id into operand registers and moves to EXEC.
  - If no request is valid, the FSM stays in IDLE.
- **EXEC:**
  - The shared `alu` evaluates the operand registers.
  - `ans`, `overflow` and the id are captured into the result registers.
  - The FSM moves to RESP.
- **RESP:**
  - `res_valid` = 1. `res_val`, `res_of` and `res_id` are held stable until handshake.
  - On `res_valid && res_ready`:
    - Priority moves to the requester that was not just served.
    - If `res_id` = 0, the CC register is updated: ZF = (`res_val` == 0), SF = `res_val[31]`, OF = `res_of`.
    - The FSM returns to IDLE.
- Arithmetic is 32-bit two's complement, and the result wraps. OF is signed overflow for add/sub and 0 for and/xor.
- Port 1 results never modify CC.
- Requester inputs are sampled only at acceptance. Changes in later cycles do not affect the in-flight operation.

## Timing
- Reset values:
  - State = IDLE.
  - `req0_ready` = `req1_ready` = 0 during reset.
  - `res_valid` = 0, `res_id` = 0, `res_val` = 0, `res_of` = 0.
  - Priority = `START_PRIO`.
  - CC = ZF 1, SF 0, OF 0.
- Latency:
  - Acceptance happens on the edge at the end of cycle N.
  - `res_valid` rises in cycle N+2.
  - The CC update is visible in the cycle after the result handshake.
- Throughput: at best one operation per 3 cycles, since RESP→IDLE costs one cycle and there is no overlap.
- Backpressure: `res_ready` = 0 holds RESP indefinitely. No new request is accepted and both `reqN_ready` stay 0.
- Simultaneous requests in IDLE: only one is granted. The loser keeps `valid` high and is granted on the next IDLE visit, because priority has rotated.
- A single requester that repeatedly requests is served every IDLE visit; priority only matters under contention.
- Reset asserted mid-operation: the block returns immediately to IDLE. The in-flight operation is discarded, no CC update occurs, and all outputs take their reset values.

## Configuration
- `ALU_ARB_CC_EN` defined:
  - The CC register and update logic are present, as described above.
- `ALU_ARB_CC_EN` undefined:
  - No CC register is built; `cc_zf`, `cc_sf` and `cc_of` are tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then port 0 add 0x7FFFFFFF + 0x00000001 with `res_ready`=1:
  - `res_valid` appears 2 cycles after acceptance with `res_val`=0x80000000, `res_of`=1, `res_id`=0.
  - After the handshake, CC = ZF0 SF1 OF1.
- Port 1 sub 5 − 5: `res_val`=0, `res_id`=1, `res_of`=0, and CC is unchanged from its reset value (ZF1 SF0 OF0).
- Both ports valid continuously with `START_PRIO`=0: grants alternate 0,1,0,1 and each `res_id` matches its grant order.
- Hold `res_ready`=0 for 10 cycles in RESP while port 0 is valid:
  - `res_*` stay stable and `req0_ready` stays 0.
  - After `res_ready` rises, port 0 is accepted in the following IDLE cycle.
- Port 0 and 0xF0F0F0F0 & 0xFF00FF00 → `res_val`=0xF000F000, `res_of`=0; xor 0xAAAAAAAA ^ 0xAAAAAAAA → 0 and ZF=1.
- Assert `rst_n`=0 during EXEC: `res_valid` stays 0, CC returns to ZF1 SF0 OF0, and priority returns to `START_PRIO`.
